// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern generator.
package seq_pkg;

   localparam int         SEQ_PAT_W   = 4;
   localparam int         SEQ_CNT_W   = 8;
   localparam int         SEQ_GAP_W   = 4;
   localparam logic [3:0] SEQ_DEF_PAT = 4'b1011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-load, MSB-first shift register.
// The MSB of a pattern goes straight to the registered serial output on load,
// so this block only stores the remaining W-1 bits. It exposes the bit that
// goes out on the next shift, plus a flag that is set while the LSB is on the line.
module seq_piso_shift #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         shift,
   input  logic [W-2:0] din_rest,
   output logic         dout_next,
   output logic         last
);

   logic [W-2:0] rest;
   logic [W-2:0] tag;

   // Load the trailing bits and a ones-marker, then shift both left together.
   always_ff @(posedge clk) begin
      if (reset) begin
         rest <= '0;
         tag  <= '0;
      end else if (load) begin
         rest <= din_rest;
         tag  <= '1;
      end else if (shift) begin
         rest <= rest << 1;
         tag  <= tag << 1;
      end
   end

   assign dout_next = rest[W-2];
   assign last      = ~|tag;

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator. It sends a latched pattern MSB-first for a
// requested number of repetitions. An optional idle gap separates the
// repetitions.
//
// state  | meaning
// S_IDLE | waiting for start with a nonzero repeat count
// S_SEND | shifting pattern bits onto x_out, one per cycle
// S_GAP  | idle cycles between repetitions, busy held high
module seq_pattern_gen
   import seq_pkg::*;
#(
   parameter int               PAT_W   = SEQ_PAT_W,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT),
   parameter int               CNT_W   = SEQ_CNT_W,
   parameter int               GAP_W   = SEQ_GAP_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             use_def,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap_len,
   input  logic             abort,
   output logic             x_out,
   output logic             x_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   state_t           state, state_d;
   logic [PAT_W-1:0] pat_q, pat_d, load_val;
   logic [CNT_W-1:0] rem, rem_d;
   logic [GAP_W-1:0] gap_q, gap_d, gap_cnt, gap_cnt_d;
   logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
   logic             load, shift, dout_next, last;
   logic             x_out_d, x_valid_d, frame_d, busy_d, done_d;

   seq_piso_shift #(.W(PAT_W)) u_piso (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .shift     (shift),
      .din_rest  (load_val[PAT_W-2:0]),
      .dout_next (dout_next),
      .last      (last)
   );

   // Next-state, counter updates and next values of the registered outputs.
   always_comb begin
      state_d   = state;
      pat_d     = pat_q;
      rem_d     = rem;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt;
      bit_cnt_d = bit_cnt;
      load_val  = pat_q;
      load      = 1'b0;
      shift     = 1'b0;
      done_d    = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (start && (repeat_cnt != '0)) begin
               load_val  = use_def ? DEF_PAT : pattern_in;
               pat_d     = load_val;
               rem_d     = repeat_cnt;
               gap_d     = gap_len;
               load      = 1'b1;
               bit_cnt_d = '0;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (!last) begin
               shift     = 1'b1;
               bit_cnt_d = bit_cnt + 1'b1;
            end else begin
               rem_d = rem - 1'b1;
               if (rem == CNT_W'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else if (gap_q == '0) begin
                  load      = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  gap_cnt_d = gap_q;
                  state_d   = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (gap_cnt == GAP_W'(1)) begin
               load      = 1'b1;
               bit_cnt_d = '0;
               state_d   = S_SEND;
            end else begin
               gap_cnt_d = gap_cnt - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d != S_IDLE);
      x_valid_d = (state_d == S_SEND);
      frame_d   = x_valid_d && (bit_cnt_d == '0) && load;
      x_out_d   = load ? load_val[PAT_W-1] : (shift ? dout_next : 1'b0);
   end

   // State, latched parameters, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         pat_q       <= '0;
         rem         <= '0;
         gap_q       <= '0;
         gap_cnt     <= '0;
         bit_cnt     <= '0;
         x_out       <= 1'b0;
         x_valid     <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_d;
         pat_q       <= pat_d;
         rem         <= rem_d;
         gap_q       <= gap_d;
         gap_cnt     <= gap_cnt_d;
         bit_cnt     <= bit_cnt_d;
         x_out       <= x_out_d;
         x_valid     <= x_valid_d;
         frame_start <= frame_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen. Each expected cycle is a tuple
// {x_out, x_valid, frame_start, busy, done}. The tuples are queued when a
// transfer is launched and popped on the falling edge after each active edge.
module tb_seq_pattern_gen;

   logic       clk = 1'b0;
   logic       reset, start, use_def, abort;
   logic [3:0] pattern_in;
   logic [7:0] repeat_cnt;
   logic [3:0] gap_len;
   logic       x_out, x_valid, frame_start, busy, done;

   logic [4:0] sbq[$];
   int         checks = 0;
   int         errors = 0;

   seq_pattern_gen dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .use_def     (use_def),
      .pattern_in  (pattern_in),
      .repeat_cnt  (repeat_cnt),
      .gap_len     (gap_len),
      .abort       (abort),
      .x_out       (x_out),
      .x_valid     (x_valid),
      .frame_start (frame_start),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] obs();
      return {x_out, x_valid, frame_start, busy, done};
   endfunction

   // Reference model of one transfer: the bits, the gap cycles and the done pulse.
   function automatic void push_transfer(input logic [3:0] pat, input int reps, input int gap);
      for (int r = 0; r < reps; r++) begin
         for (int b = 0; b < 4; b++)
            sbq.push_back({pat[3-b], 1'b1, (b == 0), 1'b1, 1'b0});
         if (r < reps - 1)
            for (int g = 0; g < gap; g++) sbq.push_back(5'b00010);
      end
      sbq.push_back(5'b00001);
   endfunction

   task automatic launch(input logic ud, input logic [3:0] pat, input int reps, input int gap);
      @(negedge clk);
      start      = 1'b1;
      use_def    = ud;
      pattern_in = pat;
      repeat_cnt = 8'(reps);
      gap_len    = 4'(gap);
   endtask

   task automatic test_reset();
      logic [4:0] e;
      reset = 1'b1; start = 1'b1; abort = 1'b1;
      use_def = 1'b1; pattern_in = 4'h0; repeat_cnt = 8'd1; gap_len = 4'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = 5'b00000;
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL reset cyc %0d: got %b want %b", i, obs(), e);
         end
         if (i == 2) begin reset = 1'b0; start = 1'b0; abort = 1'b0; end
      end
   endtask

   task automatic test_single_default();
      logic [4:0] e;
      int n;
      push_transfer(4'b1011, 1, 0);
      sbq.push_back(5'b00000);
      n = sbq.size();
      launch(1'b1, 4'b0000, 1, 0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL single_default cyc %0d: got %b want %b", i, obs(), e);
         end
         if (i == 0) start = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] e;
      int n;
      push_transfer(4'b1100, 3, 0);
      sbq.push_back(5'b00000);
      n = sbq.size();
      launch(1'b0, 4'b1100, 3, 0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs(), e);
         end
         if (i == 0) start = 1'b0;
      end
   endtask

   task automatic test_gap();
      logic [4:0] e;
      int n, busy_cycles;
      busy_cycles = 0;
      push_transfer(4'b1011, 2, 2);
      sbq.push_back(5'b00000);
      n = sbq.size();
      launch(1'b0, 4'b1011, 2, 2);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         if (busy === 1'b1) busy_cycles++;
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL gap cyc %0d: got %b want %b", i, obs(), e);
         end
         if (i == 0) start = 1'b0;
      end
      checks++;
      if (busy_cycles != 10) begin
         errors++;
         $display("FAIL gap_busy_count: got %0d want 10", busy_cycles);
      end
   endtask

   task automatic test_zero_reps();
      logic [4:0] e;
      launch(1'b1, 4'b1111, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = 5'b00000;
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL zero_reps cyc %0d: got %b want %b", i, obs(), e);
         end
         if (i == 1) start = 1'b0;
      end
   endtask

   task automatic test_start_while_busy();
      logic [4:0] e;
      int n, bits;
      bits = 0;
      push_transfer(4'b0110, 3, 0);
      sbq.push_back(5'b00000);
      n = sbq.size();
      launch(1'b0, 4'b0110, 3, 0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         if (x_valid === 1'b1) bits++;
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL start_busy cyc %0d: got %b want %b", i, obs(), e);
         end
         if (i == 0) start = 1'b0;
         if (i == 1) begin
            start = 1'b1; use_def = 1'b1; pattern_in = 4'b1111;
            repeat_cnt = 8'd5; gap_len = 4'd3;
         end
         if (i == 2) start = 1'b0;
      end
      checks++;
      if (bits != 12) begin
         errors++;
         $display("FAIL start_busy_bits: got %0d want 12", bits);
      end
   endtask

   task automatic test_abort();
      logic [4:0] e;
      int n;
      push_transfer(4'b1010, 3, 0);
      while (sbq.size() > 6) void'(sbq.pop_back());
      sbq.push_back(5'b00000);
      push_transfer(4'b1011, 1, 0);
      sbq.push_back(5'b00000);
      n = sbq.size();
      launch(1'b0, 4'b1010, 3, 0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL abort cyc %0d: got %b want %b", i, obs(), e);
         end
         if (i == 0) start = 1'b0;
         if (i == 5) begin
            abort = 1'b1; start = 1'b1;
         end
         if (i == 6) begin
            abort = 1'b0; start = 1'b1; use_def = 1'b1;
            repeat_cnt = 8'd1; gap_len = 4'd0;
         end
         if (i == 7) start = 1'b0;
      end
   endtask

   task automatic test_reset_in_gap();
      logic [4:0] e;
      int n;
      push_transfer(4'b1001, 2, 3);
      while (sbq.size() > 5) void'(sbq.pop_back());
      sbq.push_back(5'b00000);
      sbq.push_back(5'b00000);
      sbq.push_back(5'b00000);
      n = sbq.size();
      launch(1'b0, 4'b1001, 2, 3);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL reset_in_gap cyc %0d: got %b want %b", i, obs(), e);
         end
         if (i == 0) start = 1'b0;
         if (i == 4) begin
            reset = 1'b1; start = 1'b1; use_def = 1'b1; repeat_cnt = 8'd1;
         end
         if (i == 5) begin
            reset = 1'b0; start = 1'b0;
         end
      end
   endtask

   task automatic test_done_restart();
      logic [4:0] e;
      int n;
      push_transfer(4'b0110, 1, 0);
      push_transfer(4'b1001, 1, 0);
      sbq.push_back(5'b00000);
      n = sbq.size();
      launch(1'b0, 4'b0110, 1, 0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL done_restart cyc %0d: got %b want %b", i, obs(), e);
         end
         if (i == 0) start = 1'b0;
         if (i == 4) begin
            start = 1'b1; use_def = 1'b0; pattern_in = 4'b1001;
            repeat_cnt = 8'd1; gap_len = 4'd0;
         end
         if (i == 5) start = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single_default();
      test_back_to_back();
      test_gap();
      test_zero_reps();
      test_start_while_busy();
      test_abort();
      test_reset_in_gap();
      test_done_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
